// File: rtl/hp_ctrl_pkg.sv
// Shared game definitions: HP controller state encoding, default HP limits
// and the saturating HP increment used wherever HP is healed.
package hp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        INVULN = 2'd2,
        DEAD   = 2'd3
    } hp_state_t;

    localparam int unsigned HP_MAX_DEF        = 32'd9;
    localparam int unsigned HP_INIT_DEF       = 32'd9;
    localparam int unsigned INVULN_FRAMES_DEF = 32'd60;

    function automatic logic [3:0] hp_sat_inc(input logic [3:0] hp, input logic [3:0] hp_max);
        logic [3:0] res;
        if (hp >= hp_max) begin
            res = hp_max;
        end else begin
            res = hp + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/hp_ctrl_frame_tick.sv
// Rising-edge detector on vertical blank: one tick per frame, reusable by any
// frame-synchronous game logic.
module frame_tick (
    input  logic clk,
    input  logic rst,
    input  logic vblnk,
    output logic tick
);

    logic vblnk_d_r;

    // Delayed copy of vblnk for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_d_r <= 1'b0;
        end else begin
            vblnk_d_r <= vblnk;
        end
    end

    assign tick = vblnk & ~vblnk_d_r;

endmodule

// File: rtl/hp_ctrl.sv
// Frame-synchronous hit-point controller: gameplay events are latched during
// the frame and applied only at the vblank rising edge.
module hp_ctrl
    import hp_ctrl_pkg::*;
#(
    parameter int unsigned HP_MAX        = HP_MAX_DEF,
    parameter int unsigned HP_INIT       = HP_INIT_DEF,
    parameter int unsigned INVULN_FRAMES = INVULN_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       game_start,
    input  logic       hit,
    input  logic       heal,
    output logic [3:0] hp_out,
    output logic       invuln,
    output logic       blink,
    output logic       game_over
);

    localparam logic [3:0] HP_MAX_L  = 4'(HP_MAX);
    localparam logic [3:0] HP_INIT_L = 4'(HP_INIT);
    localparam logic [7:0] INV_L     = 8'(INVULN_FRAMES);

    hp_state_t  state_r, state_s;
    logic [3:0] hp_r, hp_s;
    logic [7:0] cnt_r, cnt_s;
    logic       hit_p_r, hit_p_s;
    logic       heal_p_r, heal_p_s;
    logic       invuln_r, blink_r, game_over_r;
    logic       tick_s;

    frame_tick u_frame_tick (
        .clk   (clk),
        .rst   (rst),
        .vblnk (vblnk),
        .tick  (tick_s)
    );

    // Next-state, HP and pending-event logic; game_start overrides everything.
    always_comb begin
        state_s = state_r;
        hp_s    = hp_r;
        cnt_s   = cnt_r;
        // A pulse in the tick cycle survives the clear and waits for the next frame.
        hit_p_s  = (hit & (state_r == RUN)) | (hit_p_r & ~tick_s);
        heal_p_s = (heal & ((state_r == RUN) | (state_r == INVULN))) | (heal_p_r & ~tick_s);

        case (state_r)
            RUN: begin
                if (tick_s) begin
                    if (hit_p_r) begin
                        if (hp_r <= 4'd1) begin
                            hp_s    = 4'd0;
                            state_s = DEAD;
                        end else begin
                            hp_s    = hp_r - 4'd1;
                            cnt_s   = INV_L;
                            state_s = INVULN;
                        end
                    end else if (heal_p_r) begin
                        hp_s = hp_sat_inc(hp_r, HP_MAX_L);
                    end else begin
                        hp_s = hp_r;
                    end
                end else begin
                    hp_s = hp_r;
                end
            end
            INVULN: begin
                if (tick_s) begin
                    if (heal_p_r) begin
                        hp_s = hp_sat_inc(hp_r, HP_MAX_L);
                    end else begin
                        hp_s = hp_r;
                    end
                    cnt_s = cnt_r - 8'd1;
                    if (cnt_r == 8'd1) begin
                        state_s = RUN;
                    end else begin
                        state_s = INVULN;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            IDLE:    state_s = IDLE;
            DEAD:    state_s = DEAD;
            default: state_s = IDLE;
        endcase

        if (game_start) begin
            state_s  = RUN;
            hp_s     = HP_INIT_L;
            cnt_s    = 8'd0;
            hit_p_s  = 1'b0;
            heal_p_s = 1'b0;
        end else begin
            state_s = state_s;
        end
    end

    // State, HP, counter, pending flags and registered flag outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            hp_r        <= HP_INIT_L;
            cnt_r       <= 8'd0;
            hit_p_r     <= 1'b0;
            heal_p_r    <= 1'b0;
            invuln_r    <= 1'b0;
            blink_r     <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            hp_r        <= hp_s;
            cnt_r       <= cnt_s;
            hit_p_r     <= hit_p_s;
            heal_p_r    <= heal_p_s;
            invuln_r    <= (state_s == INVULN);
            blink_r     <= (state_s == INVULN) & cnt_s[2];
            game_over_r <= (state_s == DEAD);
        end
    end

    assign hp_out    = hp_r;
    assign invuln    = invuln_r;
    assign blink     = blink_r;
    assign game_over = game_over_r;

endmodule

// File: tb/tb_hp_ctrl.sv
// Bench for hp_ctrl: directed frames with literal checks, then random events,
// with every cycle compared against a behavioural HP model.
module tb_hp_ctrl;

    localparam int HPMAX = 9;
    localparam int HPINIT = 9;
    localparam int INVF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vblnk = 1'b0;
    logic       game_start = 1'b0;
    logic       hit = 1'b0;
    logic       heal = 1'b0;
    logic [3:0] hp_out;
    logic       invuln, blink, game_over;

    int n_assert = 0;
    int n_fail = 0;
    int fpos = 0;

    // behavioural model
    int m_hp = HPINIT;
    int m_left = 0;
    bit m_started = 1'b0;
    bit m_dead = 1'b0;
    bit m_hit_seen = 1'b0;
    bit m_heal_seen = 1'b0;
    bit m_vprev = 1'b0;

    hp_ctrl #(.HP_MAX(HPMAX), .HP_INIT(HPINIT), .INVULN_FRAMES(INVF)) dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .game_start(game_start),
        .hit(hit), .heal(heal), .hp_out(hp_out), .invuln(invuln),
        .blink(blink), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Advance the model by the clock edge that just happened, using the inputs seen there.
    task automatic model_step();
        bit tick, run, inv, nh, nl;
        tick = vblnk && !m_vprev;
        if (rst) begin
            m_vprev = 1'b0; m_hp = HPINIT; m_started = 1'b0; m_dead = 1'b0;
            m_left = 0; m_hit_seen = 1'b0; m_heal_seen = 1'b0;
        end else begin
            m_vprev = vblnk;
            if (game_start) begin
                m_started = 1'b1; m_dead = 1'b0; m_hp = HPINIT; m_left = 0;
                m_hit_seen = 1'b0; m_heal_seen = 1'b0;
            end else begin
                run = m_started && !m_dead && (m_left == 0);
                inv = m_started && !m_dead && (m_left > 0);
                nh = hit && run;
                nl = heal && (run || inv);
                if (tick) begin
                    if (run && m_hit_seen) begin
                        if (m_hp == 1) begin
                            m_hp = 0; m_dead = 1'b1;
                        end else begin
                            m_hp = m_hp - 1; m_left = INVF;
                        end
                    end else if ((run || inv) && m_heal_seen) begin
                        m_hp = (m_hp + 1 > HPMAX) ? HPMAX : m_hp + 1;
                    end
                    if (inv) m_left = m_left - 1;
                    m_hit_seen = nh;
                    m_heal_seen = nl;
                end else begin
                    m_hit_seen = m_hit_seen | nh;
                    m_heal_seen = m_heal_seen | nl;
                end
            end
        end
    endtask

    task automatic compare();
        bit inv;
        inv = m_started && !m_dead && (m_left > 0);
        chk("hp_out", {4'd0, hp_out}, 8'(m_hp));
        chk("invuln", {7'd0, invuln}, {7'd0, inv});
        chk("blink", {7'd0, blink}, {7'd0, inv && ((m_left >> 2) & 1)});
        chk("game_over", {7'd0, game_over}, {7'd0, m_dead});
    endtask

    task automatic step(input bit h, input bit hl, input bit gs, input bit r);
        @(negedge clk);
        model_step();
        compare();
        rst = r; hit = h; heal = hl; game_start = gs;
        vblnk = (fpos < 3);
        fpos = (fpos + 1) % 20;
    endtask

    // Run until (and including) the next tick cycle, then sit just after the tick edge.
    task automatic run_frame(input int nh, input int nl, input bit hat, input bit gat);
        bit done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            bit at_tick = (fpos == 0);
            bit h = at_tick ? hat : ((nh > 0 && fpos == 5) || (nh > 1 && fpos == 7) || (nh > 2 && fpos == 9));
            bit l = !at_tick && ((nl > 0 && fpos == 6) || (nl > 1 && fpos == 8));
            step(h, l, at_tick & gat, 1'b0);
            done = at_tick;
        end
        @(posedge clk); #1;
    endtask

    task automatic hit_and_recover();
        run_frame(1, 0, 1'b0, 1'b0);
        for (int k = 0; k < INVF; k++) run_frame(0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        // reset
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("rst_hp", {4'd0, hp_out}, 8'd9);
        chk("rst_go", {7'd0, game_over}, 8'd0);
        chk("rst_inv", {7'd0, invuln}, 8'd0);
        // hits ignored in IDLE
        for (int k = 0; k < 3; k++) run_frame(3, 0, 1'b0, 1'b0);
        chk("idle_hp", {4'd0, hp_out}, 8'd9);
        // start, hit mid-frame
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        while (fpos != 10) step(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("hp_before_tick", {4'd0, hp_out}, 8'd9);
        run_frame(0, 0, 1'b0, 1'b0);
        chk("hp_after_hit", {4'd0, hp_out}, 8'd8);
        chk("inv_after_hit", {7'd0, invuln}, 8'd1);
        chk("blink_cnt4", {7'd0, blink}, 8'd1);
        // hit during INVULN ignored; invuln lasts exactly 4 ticks
        run_frame(1, 0, 1'b0, 1'b0);
        run_frame(0, 0, 1'b0, 1'b0);
        run_frame(0, 0, 1'b0, 1'b0);
        chk("inv_tick3", {7'd0, invuln}, 8'd1);
        run_frame(0, 0, 1'b0, 1'b0);
        chk("inv_tick4", {7'd0, invuln}, 8'd0);
        chk("hp_inv_hit", {4'd0, hp_out}, 8'd8);
        // three hits in one frame collapse
        run_frame(3, 0, 1'b0, 1'b0);
        chk("hp_multi_hit", {4'd0, hp_out}, 8'd7);
        for (int k = 0; k < INVF; k++) run_frame(0, 0, 1'b0, 1'b0);
        // hit in the tick cycle waits for the following tick
        run_frame(0, 0, 1'b1, 1'b0);
        chk("hp_tick_hit", {4'd0, hp_out}, 8'd7);
        chk("inv_tick_hit", {7'd0, invuln}, 8'd0);
        run_frame(0, 0, 1'b0, 1'b0);
        chk("hp_tick_hit_late", {4'd0, hp_out}, 8'd6);
        for (int k = 0; k < INVF; k++) run_frame(0, 0, 1'b0, 1'b0);
        // heal with saturation
        for (int k = 0; k < 4; k++) run_frame(0, 2, 1'b0, 1'b0);
        chk("hp_sat", {4'd0, hp_out}, 8'd9);
        for (int k = 0; k < 4; k++) hit_and_recover();
        chk("hp_five", {4'd0, hp_out}, 8'd5);
        run_frame(1, 1, 1'b0, 1'b0);
        chk("hp_hit_heal", {4'd0, hp_out}, 8'd4);
        chk("inv_hit_heal", {7'd0, invuln}, 8'd1);
        for (int k = 0; k < INVF; k++) run_frame(0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) hit_and_recover();
        chk("hp_one", {4'd0, hp_out}, 8'd1);
        run_frame(1, 0, 1'b0, 1'b0);
        chk("hp_dead", {4'd0, hp_out}, 8'd0);
        chk("go_dead", {7'd0, game_over}, 8'd1);
        run_frame(0, 2, 1'b0, 1'b0);
        run_frame(0, 1, 1'b0, 1'b0);
        chk("hp_dead_heal", {4'd0, hp_out}, 8'd0);
        // restart coincident with tick
        run_frame(0, 0, 1'b0, 1'b1);
        chk("hp_restart", {4'd0, hp_out}, 8'd9);
        chk("go_restart", {7'd0, game_over}, 8'd0);
        chk("inv_restart", {7'd0, invuln}, 8'd0);
        // reset mid-INVULN with counter at 2
        run_frame(1, 0, 1'b0, 1'b0);
        run_frame(0, 0, 1'b0, 1'b0);
        run_frame(0, 0, 1'b0, 1'b0);
        chk("inv_cnt2", {7'd0, invuln}, 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("rst2_hp", {4'd0, hp_out}, 8'd9);
        chk("rst2_inv", {7'd0, invuln}, 8'd0);
        chk("rst2_blink", {7'd0, blink}, 8'd0);
        chk("rst2_go", {7'd0, game_over}, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(2, 0, 1'b0, 1'b0);
        run_frame(1, 0, 1'b0, 1'b0);
        chk("rst2_idle_hp", {4'd0, hp_out}, 8'd9);
        // randomized traffic
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 12) == 0, ($urandom % 10) == 0,
                 ($urandom % 250) == 0, ($urandom % 700) == 0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hp_ctrl.md
Name: hp_ctrl

Overview:
- Frame-synchronous hit-point controller for the game screen.
- Owns the player HP value and drives the text overlay's `hp_in` (the "HP n" display) plus the invulnerability and game-over flags.
- Collects asynchronous-to-frame gameplay events (hit, heal, start) and applies them only at the vblank rising edge, so the displayed number never changes mid-frame.

Parameters:
- HP_MAX, 9, saturating upper bound of HP (must fit in 4 bits, ≤ 9 for single-digit display).
- HP_INIT, 9, HP loaded on reset and on game_start.
- INVULN_FRAMES, 60, frames of invulnerability after a non-fatal hit (1..255).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- vblnk  in  1  vertical blank from VGA timing (level)
- game_start  in  1  one-cycle pulse: start/restart game
- hit  in  1  one-cycle pulse: player damaged
- heal  in  1  one-cycle pulse: player healed
- hp_out  out  4  current HP, to overlay hp_in
- invuln  out  1  high while in INVULN state
- blink  out  1  invulnerability blink phase (frame counter bit 2), 0 outside INVULN
- game_over  out  1  high in DEAD state

Behaviour:
- Reset values:
  - state = IDLE, hp_out = HP_INIT.
  - invuln = 0, blink = 0, game_over = 0.
  - frame counter = 0, pending flags = 0, vblnk_d = 0.
- Frame tick:
  - vblnk_d is vblnk registered.
  - tick = vblnk & ~vblnk_d (one cycle per frame).
  - All HP and state updates caused by tick are visible on outputs the cycle after tick is high.
- Pending flags hit_p, heal_p:
  - Set by the hit/heal pulse, cleared on tick.
  - Multiple pulses in one frame collapse to one.
  - A pulse arriving in the tick cycle is not consumed by that tick; it is latched for the next frame.
- States:
  - IDLE:
    - Ignores hit/heal (flags not set).
    - game_start -> RUN, hp_out = HP_INIT.
  - RUN: on tick,
    - If hit_p and hp_out = 1 -> hp_out = 0, DEAD.
    - If hit_p and hp_out > 1 -> hp_out - 1, INVULN, counter = INVULN_FRAMES.
    - Else if heal_p -> hp_out = min(hp_out + 1, HP_MAX).
    - Hit and heal pending together: hit wins, heal discarded.
  - INVULN:
    - hit pulses are not latched.
    - heal_p is applied on tick, with saturation.
    - Counter decrements on each tick; when it decrements to 0 -> RUN.
    - invuln = 1; blink = counter[2].
  - DEAD:
    - hit/heal ignored; game_over = 1; hp_out stays 0.
    - game_start -> RUN.
- game_start in any state (including simultaneous with tick, hit, or heal) has highest priority. It forces:
  - RUN, hp_out = HP_INIT
  - counter = 0, pending flags cleared
  - invuln = 0, game_over = 0
- Arithmetic:
  - 4-bit unsigned, never wraps.
  - Decrement below 0 is impossible by construction (DEAD at 1 -> 0).
  - Increment saturates at HP_MAX.
- rst mid-operation (any state) returns to the reset values in the next cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared game package holds:
  - `hp_state_t` enum (IDLE, RUN, INVULN, DEAD)
  - HP_MAX_DEF, HP_INIT_DEF, INVULN_FRAMES_DEF constants, also reused by the overlay for digit range.
- One natural sub-module: `frame_tick`, the registered rising-edge detector on vblnk, outputting a one-cycle tick. It is reusable by other frame-synchronous game logic.

Test Plan:
- Bench uses INVULN_FRAMES = 4 and a short synthetic frame (vblnk high 3 cycles every 20).
- Reset -> hp_out = 9, game_over = 0, invuln = 0; hit pulses in IDLE leave hp_out = 9 across 3 frames.
- game_start, then a hit mid-frame -> hp_out = 9 until the cycle after the next tick, then 8. invuln = 1 for exactly 4 ticks, then 0. A hit during INVULN leaves hp_out = 8.
- In RUN, 3 hit pulses within one frame -> hp_out drops by exactly 1. A hit asserted in the tick cycle itself -> applied at the following tick.
- hp_out = 9 with heal -> stays 9. hp_out = 5 with hit + heal in the same frame -> 4, invuln = 1.
- Drive hp_out to 1, then hit -> hp_out = 0, game_over = 1. Further heals leave hp_out = 0. game_start simultaneous with a tick -> hp_out = 9, game_over = 0, state RUN.
- rst asserted mid-INVULN (counter = 2) -> next cycle hp_out = 9, invuln = 0, blink = 0, state IDLE.
